// File: rtl/stream_minmax_tracker.sv
// Per-packet min/max tracker over a valid/ready sample stream, built on a
// recursive unsigned comparator (eq/lt). One result beat per packet.

module stream_minmax_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         lt
);
  if (W == 1) begin : g_leaf
    assign eq = (a[0] == b[0]);
    assign lt = ~a[0] & b[0];
  end else begin : g_split
    localparam int H = W / 2;
    logic eq_hi, lt_hi, eq_lo, lt_lo;

    stream_minmax_cmp #(.W(W - H)) u_hi (
      .a  (a[W-1:H]),
      .b  (b[W-1:H]),
      .eq (eq_hi),
      .lt (lt_hi)
    );

    stream_minmax_cmp #(.W(H)) u_lo (
      .a  (a[H-1:0]),
      .b  (b[H-1:0]),
      .eq (eq_lo),
      .lt (lt_lo)
    );

    // Upper half decides unless it is equal, then the lower half decides.
    assign eq = eq_hi & eq_lo;
    assign lt = lt_hi | (eq_hi & lt_lo);
  end
endmodule

module stream_minmax_tracker #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_min,
  output logic [N-1:0]     out_max,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic [1:0]       dbg_state
);
  // Handshake: a beat transfers on a rising edge where valid and ready are
  // both high; out_valid never waits on out_ready, and once raised the result
  // fields are frozen until the transfer.

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACC   = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [N-1:0]     min_r, max_r;
  logic [CNT_W-1:0] min_idx_r, max_idx_r, cnt_r;
  logic             sat_r;

  logic [N-1:0]     nxt_min, nxt_max;
  logic [CNT_W-1:0] nxt_min_idx, nxt_max_idx, nxt_cnt;
  logic             nxt_sat;

  logic             min_eq, min_lt, max_eq, max_lt;
  logic             min_upd, max_upd;
  logic             in_xfer;

  assign in_xfer   = in_valid & in_ready;
  assign dbg_state = state;

  stream_minmax_cmp #(.W(N)) u_cmp_min (
    .a  (min_r),
    .b  (in_data),
    .eq (min_eq),
    .lt (min_lt)
  );

  stream_minmax_cmp #(.W(N)) u_cmp_max (
    .a  (in_data),
    .b  (max_r),
    .eq (max_eq),
    .lt (max_lt)
  );

  // Strict improvements only, so ties keep the earlier index.
  assign min_upd = ~(min_lt | min_eq);
  assign max_upd = ~(max_lt | max_eq);

  always_comb begin
    nxt_min     = min_r;
    nxt_max     = max_r;
    nxt_min_idx = min_idx_r;
    nxt_max_idx = max_idx_r;
    nxt_cnt     = cnt_r;
    nxt_sat     = sat_r;
    if (state == FIRST) begin
      nxt_min     = in_data;
      nxt_max     = in_data;
      nxt_min_idx = '0;
      nxt_max_idx = '0;
      nxt_cnt     = CNT_W'(1);
      nxt_sat     = 1'b0;
    end else begin
      // cnt_r is this sample's index, pinned at CNT_MAX once saturated.
      if (min_upd) begin
        nxt_min     = in_data;
        nxt_min_idx = cnt_r;
      end
      if (max_upd) begin
        nxt_max     = in_data;
        nxt_max_idx = cnt_r;
      end
      if (cnt_r == CNT_MAX) nxt_sat = 1'b1;
      else                  nxt_cnt = cnt_r + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FIRST;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      min_r       <= '0;
      max_r       <= '0;
      min_idx_r   <= '0;
      max_idx_r   <= '0;
      cnt_r       <= '0;
      sat_r       <= 1'b0;
      out_min     <= '0;
      out_max     <= '0;
      out_min_idx <= '0;
      out_max_idx <= '0;
      out_count   <= '0;
      out_sat     <= 1'b0;
    end else begin
      case (state)
        FIRST, ACC: begin
          in_ready <= 1'b1;
          if (in_xfer) begin
            min_r     <= nxt_min;
            max_r     <= nxt_max;
            min_idx_r <= nxt_min_idx;
            max_idx_r <= nxt_max_idx;
            cnt_r     <= nxt_cnt;
            sat_r     <= nxt_sat;
            if (in_last) begin
              state       <= HOLD;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
              out_min     <= nxt_min;
              out_max     <= nxt_max;
              out_min_idx <= nxt_min_idx;
              out_max_idx <= nxt_max_idx;
              out_count   <= nxt_cnt;
              out_sat     <= nxt_sat;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= FIRST;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            min_r     <= '0;
            max_r     <= '0;
            min_idx_r <= '0;
            max_idx_r <= '0;
            cnt_r     <= '0;
            sat_r     <= 1'b0;
          end
        end
        default: begin
          state     <= FIRST;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Bench for stream_minmax_tracker: random and directed packets, expected
// results from a per-packet reference model queued for an output monitor.

module tb_stream_minmax_tracker;
  localparam int N     = 8;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int RW    = 2 * N + 3 * CNT_W + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_min;
  logic [N-1:0]     out_max;
  logic [CNT_W-1:0] out_min_idx;
  logic [CNT_W-1:0] out_max_idx;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic [1:0]       dbg_state;

  stream_minmax_tracker #(.N(N), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_min     (out_min),
    .out_max     (out_max),
    .out_min_idx (out_min_idx),
    .out_max_idx (out_max_idx),
    .out_count   (out_count),
    .out_sat     (out_sat),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int               total = 0;
  int               bad   = 0;
  logic [RW-1:0]    exp_q[$];
  logic [N-1:0]     pkt[$];
  int               rdy_mode = 2;
  logic [N-1:0]     cap_min, cap_max;
  logic [CNT_W-1:0] cap_min_idx, cap_max_idx, cap_cnt;
  logic             cap_sat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sat_to(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  function automatic logic [RW-1:0] model_pkt();
    int mn = 0;
    int mx = 0;
    int len = pkt.size();
    for (int i = 1; i < len; i++) begin
      if (pkt[i] < pkt[mn]) mn = i;
      if (pkt[i] > pkt[mx]) mx = i;
    end
    return {pkt[mn], pkt[mx], CNT_W'(sat_to(mn)), CNT_W'(sat_to(mx)),
            CNT_W'(sat_to(len)), 1'(len > MAXC)};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [N-1:0] d, input logic l);
    int   waited = 0;
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 500) begin
        chk("in_handshake_timeout", 32'(waited), 32'(0));
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input int gap_max);
    int k;
    exp_q.push_back(model_pkt());
    for (int i = 0; i < pkt.size(); i++) begin
      send_beat(pkt[i], 1'(i == pkt.size() - 1));
      k = $urandom_range(0, gap_max);
      if (k > 0 && i != pkt.size() - 1) begin
        repeat (k) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic set_rdy(input int mode);
    rdy_mode = mode;
    @(posedge clk);
    #2;
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [RW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(exp_q.size()), 32'(1));
        end else begin
          e = exp_q.pop_front();
          chk("min",     32'(out_min),     32'(e[3*CNT_W+2*N : 3*CNT_W+N+1]));
          chk("max",     32'(out_max),     32'(e[3*CNT_W+N : 3*CNT_W+1]));
          chk("min_idx", 32'(out_min_idx), 32'(e[3*CNT_W : 2*CNT_W+1]));
          chk("max_idx", 32'(out_max_idx), 32'(e[2*CNT_W : CNT_W+1]));
          chk("count",   32'(out_count),   32'(e[CNT_W:1]));
          chk("sat",     32'(out_sat),     32'(e[0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready",  32'(in_ready),  32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_min",   32'(out_min),   32'(0));
    chk("rst_out_max",   32'(out_max),   32'(0));
    chk("rst_out_count", 32'(out_count), 32'(0));
    chk("rst_out_sat",   32'(out_sat),   32'(0));
    chk("rst_state",     32'(dbg_state), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    set_rdy(1);

    // basic packet, plus one-cycle result latency
    pkt = '{8'd5, 8'd3, 8'd9, 8'd3, 8'd9};
    send_pkt(0);
    chk("latency_out_valid", 32'(out_valid), 32'(1));
    wait_drain();

    pkt = '{8'hA7};
    send_pkt(0);
    wait_drain();

    pkt = '{8'h00, 8'hFF, 8'h80};
    send_pkt(1);
    wait_drain();

    pkt = '{8'd4, 8'd4, 8'd4, 8'd4};
    send_pkt(1);
    wait_drain();

    // back-pressure in HOLD
    set_rdy(2);
    pkt = '{8'd4, 8'd6, 8'd1, 8'd6};
    send_pkt(0);
    @(negedge clk);
    cap_min = out_min; cap_max = out_max; cap_min_idx = out_min_idx;
    cap_max_idx = out_max_idx; cap_cnt = out_count; cap_sat = out_sat;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_in_ready",  32'(in_ready),    32'(0));
      chk("hold_out_valid", 32'(out_valid),   32'(1));
      chk("hold_stable",    32'({out_min, out_max, out_min_idx, out_max_idx, out_count, out_sat}),
                            32'({cap_min, cap_max, cap_min_idx, cap_max_idx, cap_cnt, cap_sat}));
    end
    set_rdy(1);
    @(posedge clk);
    #1;
    chk("release_in_ready",  32'(in_ready),  32'(1));
    chk("release_state",     32'(dbg_state), 32'(0));
    chk("release_out_valid", 32'(out_valid), 32'(0));
    chk("release_keep_min",  32'(out_min),   32'(cap_min));
    chk("release_keep_cnt",  32'(out_count), 32'(cap_cnt));
    wait_drain();

    // saturation boundaries
    pkt.delete();
    for (int i = 0; i < MAXC; i++) pkt.push_back(N'($urandom_range(1, 254)));
    send_pkt(0);
    wait_drain();
    pkt.delete();
    for (int i = 0; i < MAXC + 1; i++) pkt.push_back(N'($urandom_range(0, 255)));
    send_pkt(0);
    wait_drain();
    pkt.delete();
    for (int i = 0; i < 300; i++) pkt.push_back((i == 270) ? 8'd0 : ((i == 280) ? 8'd2 : 8'd1));
    send_pkt(0);
    wait_drain();

    // reset mid-packet discards it
    send_beat(8'd50, 1'b0);
    send_beat(8'd60, 1'b0);
    #2;
    rst_n = 1'b0;
    #2;
    chk("midrst_in_ready",  32'(in_ready),  32'(0));
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_out_min",   32'(out_min),   32'(0));
    chk("midrst_out_count", 32'(out_count), 32'(0));
    chk("midrst_state",     32'(dbg_state), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pkt = '{8'd7, 8'd2};
    send_pkt(0);
    wait_drain();

    // reset while holding a result drops it
    set_rdy(2);
    send_beat(8'd5, 1'b0);
    send_beat(8'd9, 1'b1);
    @(negedge clk);
    chk("pre_rst_hold_valid", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    #2;
    chk("holdrst_out_valid", 32'(out_valid), 32'(0));
    chk("holdrst_out_max",   32'(out_max),   32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic with random back-pressure
    set_rdy(0);
    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, 12);
      int narrow = $urandom_range(0, 1);
      pkt.delete();
      for (int i = 0; i < len; i++)
        pkt.push_back(narrow ? N'($urandom_range(0, 3)) : N'($urandom_range(0, 255)));
      send_pkt(2);
    end
    set_rdy(1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
